// File: rtl/moore_seq_ctrl.sv
// Programmable Moore sequence detector: shifts accepted serial bits into a history
// register and raises a registered detect flag when the history matches a loaded pattern.
// Optional saturating hit counter is built only when MSD_HIT_COUNTER_EN is defined.
module moore_seq_ctrl #(
  parameter int unsigned PAT_W   = 4,
  parameter int unsigned OVERLAP = 1,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_clear,
  input  logic             din_valid,
  input  logic             din,
  output logic             armed,
  output logic             detect,
  output logic [CNT_W-1:0] hit_count
);

  localparam int unsigned FillW = $clog2(PAT_W + 1);
  localparam logic [FillW-1:0] FillFull = FillW'(PAT_W);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [FillW-1:0] fill_q, fill_d;
  logic             detect_q, detect_d;

  logic             accept;
  logic             match;
  logic [PAT_W-1:0] hist_shift;
  logic [FillW-1:0] fill_inc;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      pattern_q <= '0;
      hist_q    <= '0;
      fill_q    <= '0;
      detect_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      detect_q  <= detect_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d    = state_q;
    pattern_d  = pattern_q;
    hist_d     = hist_q;
    fill_d     = fill_q;
    hist_shift = {hist_q[PAT_W-2:0], din};
    fill_inc   = (fill_q == FillFull) ? fill_q : fill_q + FillW'(1);
    // Any strobe drops the bit arriving in the same cycle
    accept     = (state_q == StRun) && din_valid && !cfg_load && !cfg_clear;
    match      = accept && (fill_inc == FillFull) && (hist_shift == pattern_q);
    detect_d   = match;

    unique case (state_q)
      StIdle: begin
        if (cfg_load) state_d = StRun;
      end
      StRun: begin
        if (!cfg_load && cfg_clear) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (cfg_load) begin
      pattern_d = cfg_pattern;
      hist_d    = '0;
      fill_d    = '0;
    end else if (accept) begin
      hist_d = hist_shift;
      fill_d = (match && (OVERLAP == 0)) ? '0 : fill_inc;
    end
  end

`ifdef MSD_HIT_COUNTER_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cfg_load)                             cnt_d = '0;
    else if (match && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end
`endif

  // Outputs
  always_comb begin
    armed  = (state_q == StRun);
    detect = detect_q;
`ifdef MSD_HIT_COUNTER_EN
    hit_count = cnt_q;
`else
    hit_count = '0;
`endif
  end

endmodule

// File: tb/tb_moore_seq_ctrl.sv
// Directed bench for moore_seq_ctrl: one overlapping and one non-overlapping instance
// share stimulus; table vectors plus hand-written reset and saturation sequences.
module tb_moore_seq_ctrl;

`ifdef MSD_HIT_COUNTER_EN
  localparam bit HC = 1'b1;
`else
  localparam bit HC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cfg_load = 1'b0;
  logic       cfg_clear = 1'b0;
  logic [3:0] cfg_pattern = '0;
  logic       din_valid = 1'b0;
  logic       din = 1'b0;

  logic       armed_ov, detect_ov, armed_no, detect_no;
  logic [7:0] hit_ov, hit_no;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  moore_seq_ctrl #(.PAT_W(4), .OVERLAP(1), .CNT_W(8)) u_ov (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_clear(cfg_clear), .din_valid(din_valid), .din(din),
    .armed(armed_ov), .detect(detect_ov), .hit_count(hit_ov)
  );

  moore_seq_ctrl #(.PAT_W(4), .OVERLAP(0), .CNT_W(8)) u_no (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_clear(cfg_clear), .din_valid(din_valid), .din(din),
    .armed(armed_no), .detect(detect_no), .hit_count(hit_no)
  );

  typedef struct {
    logic       load;
    logic       clear;
    logic [3:0] pat;
    logic       dv;
    logic       d;
    logic       det_ov;
    logic       det_no;
    logic       arm;
    int         h_ov;
    int         h_no;
  } vec_t;

  vec_t vecs[$];

  function automatic int eh(input int v);
    return HC ? v : 0;
  endfunction

  task automatic add(input logic load, input logic clear, input logic [3:0] pat,
                     input logic dv, input logic d, input logic det_ov, input logic det_no,
                     input logic arm, input int h_ov, input int h_no);
    vec_t v;
    v.load = load; v.clear = clear; v.pat = pat; v.dv = dv; v.d = d;
    v.det_ov = det_ov; v.det_no = det_no; v.arm = arm; v.h_ov = h_ov; v.h_no = h_no;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Drive at negedge, settle 1 time unit after the consuming posedge
  task automatic drive(input logic load, input logic clear, input logic [3:0] pat,
                       input logic dv, input logic d);
    @(negedge clk);
    cfg_load = load; cfg_clear = clear; cfg_pattern = pat; din_valid = dv; din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic det_ov, input logic det_no,
                           input logic arm, input int h_ov, input int h_no);
    check({tag, " detect_ov"}, int'(detect_ov), int'(det_ov));
    check({tag, " detect_no"}, int'(detect_no), int'(det_no));
    check({tag, " armed_ov"}, int'(armed_ov), int'(arm));
    check({tag, " armed_no"}, int'(armed_no), int'(arm));
    check({tag, " hit_ov"}, int'(hit_ov), eh(h_ov));
    check({tag, " hit_no"}, int'(hit_no), eh(h_no));
  endtask

  initial begin
    // Idle behaviour and stray strobes
    add(0, 0, 4'b0000, 1, 1, 0, 0, 0, 0, 0);
    add(0, 1, 4'b0000, 1, 1, 0, 0, 0, 0, 0);
    // T1/T2: pattern 1011, stream 1,0,1,1,0,1,1
    add(1, 0, 4'b1011, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 4'b0000, 1, 1, 0, 0, 1, 0, 0);
    add(0, 0, 4'b0000, 1, 0, 0, 0, 1, 0, 0);
    add(0, 0, 4'b0000, 1, 1, 0, 0, 1, 0, 0);
    add(0, 0, 4'b0000, 1, 1, 1, 1, 1, 1, 1);
    add(0, 0, 4'b0000, 1, 0, 0, 0, 1, 1, 1);
    add(0, 0, 4'b0000, 1, 1, 0, 0, 1, 1, 1);
    add(0, 0, 4'b0000, 1, 1, 1, 0, 1, 2, 1);
    add(0, 0, 4'b0000, 0, 0, 0, 0, 1, 2, 1);
    // T3: pattern 1111, six 1s
    add(1, 0, 4'b1111, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 4'b0000, 1, 1, 0, 0, 1, 0, 0);
    add(0, 0, 4'b0000, 1, 1, 0, 0, 1, 0, 0);
    add(0, 0, 4'b0000, 1, 1, 0, 0, 1, 0, 0);
    add(0, 0, 4'b0000, 1, 1, 1, 1, 1, 1, 1);
    add(0, 0, 4'b0000, 1, 1, 1, 0, 1, 2, 1);
    add(0, 0, 4'b0000, 1, 1, 1, 0, 1, 3, 1);
    add(0, 0, 4'b0000, 0, 0, 0, 0, 1, 3, 1);
    // T4: 1,0 / three gaps / 1,1
    add(1, 0, 4'b1011, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 4'b0000, 1, 1, 0, 0, 1, 0, 0);
    add(0, 0, 4'b0000, 1, 0, 0, 0, 1, 0, 0);
    add(0, 0, 4'b0000, 0, 1, 0, 0, 1, 0, 0);
    add(0, 0, 4'b0000, 0, 1, 0, 0, 1, 0, 0);
    add(0, 0, 4'b0000, 0, 1, 0, 0, 1, 0, 0);
    add(0, 0, 4'b0000, 1, 1, 0, 0, 1, 0, 0);
    add(0, 0, 4'b0000, 1, 1, 1, 1, 1, 1, 1);
    add(0, 0, 4'b0000, 0, 0, 0, 0, 1, 1, 1);
    // T6: bit with load is dropped, so 0,1,1 leaves fill at 3 and no match
    add(1, 0, 4'b1011, 1, 1, 0, 0, 1, 0, 0);
    add(0, 0, 4'b0000, 1, 0, 0, 0, 1, 0, 0);
    add(0, 0, 4'b0000, 1, 1, 0, 0, 1, 0, 0);
    add(0, 0, 4'b0000, 1, 1, 0, 0, 1, 0, 0);
    // Clear with a bit, then load+clear together (load wins)
    add(0, 1, 4'b0000, 1, 1, 0, 0, 0, 0, 0);
    add(1, 1, 4'b1011, 1, 1, 0, 0, 1, 0, 0);
    // Match, then clear: detect drops, count retained
    add(0, 0, 4'b0000, 1, 1, 0, 0, 1, 0, 0);
    add(0, 0, 4'b0000, 1, 0, 0, 0, 1, 0, 0);
    add(0, 0, 4'b0000, 1, 1, 0, 0, 1, 0, 0);
    add(0, 0, 4'b0000, 1, 1, 1, 1, 1, 1, 1);
    add(0, 1, 4'b0000, 0, 0, 0, 0, 0, 1, 1);
    // Reload coinciding with what would be a completing bit
    add(1, 0, 4'b1011, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 4'b0000, 1, 1, 0, 0, 1, 0, 0);
    add(0, 0, 4'b0000, 1, 0, 0, 0, 1, 0, 0);
    add(0, 0, 4'b0000, 1, 1, 0, 0, 1, 0, 0);
    add(1, 0, 4'b1011, 1, 1, 0, 0, 1, 0, 0);

    // Reset state, asserted before any clock
    #2;
    check_all("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].load, vecs[i].clear, vecs[i].pat, vecs[i].dv, vecs[i].d);
      check_all($sformatf("v%0d", i), vecs[i].det_ov, vecs[i].det_no, vecs[i].arm,
                vecs[i].h_ov, vecs[i].h_no);
    end

    // T5: async reset mid-stream while detect is high
    drive(1, 0, 4'b1011, 0, 0);
    drive(0, 0, 4'b0000, 1, 1);
    drive(0, 0, 4'b0000, 1, 0);
    drive(0, 0, 4'b0000, 1, 1);
    drive(0, 0, 4'b0000, 1, 1);
    check_all("t5 pre", 1, 1, 1, 1, 1);
    #2;
    rst = 1'b0;
    #1;
    check_all("t5 async", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    din_valid = 1'b0;
    for (int k = 0; k < 5; k++) drive(0, 0, 4'b0000, 1, 1);
    check_all("t5 idle", 0, 0, 0, 0, 0);
    drive(1, 0, 4'b1011, 0, 0);
    check_all("t5 rearm", 0, 0, 1, 0, 0);

    // T6: 303 ones against 1111 -> 300 overlapping matches, 75 non-overlapping
    drive(1, 0, 4'b1111, 0, 0);
    for (int k = 0; k < 303; k++) drive(0, 0, 4'b0000, 1, 1);
    check_all("sat", 1, 0, 1, 255, 75);
    drive(0, 1, 4'b0000, 0, 0);
    check_all("sat clear", 0, 0, 0, 255, 75);
    drive(1, 0, 4'b1111, 0, 0);
    check_all("sat reload", 0, 0, 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
